// File: rtl/ibex_pkg.sv
// Shared types and limits for the multi-entry writeback stage.
// Holds the instruction class encoding and the per-entry record kept in the writeback FIFO.
package ibex_pkg;

  localparam int WB_DEPTH_MAX = 4;
  localparam int WB_AUX_MAX   = 4;

  typedef enum logic [1:0] {
    WB_INSTR_LOAD  = 2'b00,
    WB_INSTR_STORE = 2'b01,
    WB_INSTR_OTHER = 2'b10
  } wb_instr_type_e;

  typedef struct packed {
    wb_instr_type_e instr_type;
    logic [31:0]    pc;
    logic           compressed;
    logic           count;
    logic           we;
    logic [4:0]     waddr;
    logic [31:0]    wdata;
  } wb_entry_t;

endpackage

// File: rtl/ibex_wb_aux_arb.sv
// Fixed-priority arbiter for auxiliary RF writers, with a starvation counter.
// Once the counter saturates, yield_o asks the writeback head to give up one write slot.
module ibex_wb_aux_arb #(
  parameter int NumAuxSrc      = 2,
  parameter int AuxStarveLimit = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic [NumAuxSrc-1:0] req_i,
  input  logic                 port_busy_i,
  output logic [NumAuxSrc-1:0] gnt_o,
  output logic                 yield_o
);

  localparam logic [7:0] Limit = 8'(AuxStarveLimit);

  logic [7:0] cnt_q, cnt_d;
  logic       granted;

  assign yield_o = (cnt_q == Limit);

  always_comb begin
    gnt_o   = '0;
    granted = 1'b0;
    for (int i = 0; i < NumAuxSrc; i++) begin
      if (req_i[i] && !port_busy_i && !granted) begin
        gnt_o[i] = 1'b1;
        granted  = 1'b1;
      end
    end
  end

  // Waiting requests age the counter; any grant restarts it.
  always_comb begin
    cnt_d = cnt_q;
    if (|gnt_o) begin
      cnt_d = '0;
    end else if ((|req_i) && (cnt_q != Limit)) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  a_gnt_onehot0 : assert property (@(posedge clk_i) disable iff (!rst_ni) $onehot0(gnt_o));

endmodule

// File: rtl/ibex_wb_stage_mq.sv
// Multi-entry in-order writeback stage: a small circular FIFO of instructions from ID/EX
// retiring from the head onto the single RF write port, shared with auxiliary writers.
module ibex_wb_stage_mq import ibex_pkg::*; #(
  parameter int WbDepth        = 2,
  parameter int NumAuxSrc      = 2,
  parameter int AuxStarveLimit = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    en_wb_i,
  input  wb_instr_type_e          instr_type_wb_i,
  input  logic [31:0]             pc_id_i,
  input  logic                    instr_is_compressed_id_i,
  input  logic                    instr_perf_count_id_i,
  input  logic [4:0]              rf_waddr_id_i,
  input  logic [31:0]             rf_wdata_id_i,
  input  logic                    rf_we_id_i,
  input  logic [4:0]              rf_raddr_a_i,
  input  logic [4:0]              rf_raddr_b_i,
  input  logic [31:0]             rf_wdata_lsu_i,
  input  logic                    rf_we_lsu_i,
  input  logic                    lsu_resp_valid_i,
  input  logic                    lsu_resp_err_i,
  input  logic [NumAuxSrc-1:0]    aux_req_i,
  input  logic [NumAuxSrc*5-1:0]  aux_waddr_i,
  input  logic [NumAuxSrc*32-1:0] aux_wdata_i,
  output logic [NumAuxSrc-1:0]    aux_gnt_o,
  output logic                    ready_wb_o,
  output logic                    rf_hazard_a_o,
  output logic                    rf_hazard_b_o,
  output logic                    outstanding_load_wb_o,
  output logic                    outstanding_store_wb_o,
  output logic [31:0]             pc_wb_o,
  output logic                    instr_done_wb_o,
  output logic                    perf_instr_ret_wb_o,
  output logic                    perf_instr_ret_compressed_wb_o,
  output logic [2:0]              occupancy_o,
  output logic [4:0]              rf_waddr_wb_o,
  output logic [31:0]             rf_wdata_wb_o,
  output logic                    rf_we_wb_o
);

  localparam logic [1:0] LastPtr  = 2'(WbDepth - 1);
  localparam logic [2:0] DepthOcc = 3'(WbDepth);

  // Storage is sized for the largest depth so pointers index it exactly; slots past WbDepth stay idle.
  wb_entry_t                 mem_q [WB_DEPTH_MAX];
  wb_entry_t                 mem_d [WB_DEPTH_MAX];
  logic [WB_DEPTH_MAX-1:0]   valid_q, valid_d;
  logic [1:0]                rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [2:0]                occ_q, occ_d;

  wb_entry_t head;
  wb_entry_t new_entry;
  logic      head_valid, head_is_other, head_retire, enq, yield;
  logic      lsu_wr, other_wr, port_busy;

  function automatic logic [1:0] ptr_inc(input logic [1:0] p);
    return (p == LastPtr) ? 2'd0 : p + 2'd1;
  endfunction

  always_comb begin
    head          = mem_q[rd_ptr_q];
    head_valid    = valid_q[rd_ptr_q];
    head_is_other = head.instr_type == WB_INSTR_OTHER;
    head_retire   = 1'b0;
    if (head_valid) begin
      head_retire = head_is_other ? !(head.we && yield) : lsu_resp_valid_i;
    end
    ready_wb_o = (occ_q != DepthOcc) || head_retire;
    enq        = en_wb_i && ready_wb_o;
  end

  always_comb begin
    new_entry.instr_type = instr_type_wb_i;
    new_entry.pc         = pc_id_i;
    new_entry.compressed = instr_is_compressed_id_i;
    new_entry.count      = instr_perf_count_id_i;
    new_entry.we         = rf_we_id_i;
    new_entry.waddr      = rf_waddr_id_i;
    new_entry.wdata      = rf_wdata_id_i;
  end

  // Retire is applied before enqueue so a full queue can recycle its head slot in one cycle.
  always_comb begin
    mem_d    = mem_q;
    valid_d  = valid_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    occ_d    = occ_q;
    if (head_retire) begin
      valid_d[rd_ptr_q] = 1'b0;
      rd_ptr_d          = ptr_inc(rd_ptr_q);
    end
    if (enq) begin
      mem_d[wr_ptr_q]   = new_entry;
      valid_d[wr_ptr_q] = 1'b1;
      wr_ptr_d          = ptr_inc(wr_ptr_q);
    end
    unique case ({enq, head_retire})
      2'b10:   occ_d = occ_q + 3'd1;
      2'b01:   occ_d = occ_q - 3'd1;
      default: occ_d = occ_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < WB_DEPTH_MAX; i++) begin
        mem_q[i] <= '0;
      end
      valid_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      valid_q  <= valid_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      occ_q    <= occ_d;
    end
  end

  // Loads are hazards even without we: their data has not arrived yet.
  always_comb begin
    rf_hazard_a_o          = 1'b0;
    rf_hazard_b_o          = 1'b0;
    outstanding_load_wb_o  = 1'b0;
    outstanding_store_wb_o = 1'b0;
    for (int i = 0; i < WB_DEPTH_MAX; i++) begin
      if (valid_q[i]) begin
        if ((mem_q[i].we || mem_q[i].instr_type == WB_INSTR_LOAD) &&
            (rf_raddr_a_i != 5'd0) && (mem_q[i].waddr == rf_raddr_a_i)) begin
          rf_hazard_a_o = 1'b1;
        end
        if ((mem_q[i].we || mem_q[i].instr_type == WB_INSTR_LOAD) &&
            (rf_raddr_b_i != 5'd0) && (mem_q[i].waddr == rf_raddr_b_i)) begin
          rf_hazard_b_o = 1'b1;
        end
        if (mem_q[i].instr_type == WB_INSTR_LOAD) outstanding_load_wb_o = 1'b1;
        if (mem_q[i].instr_type == WB_INSTR_STORE) outstanding_store_wb_o = 1'b1;
      end
    end
  end

  assign pc_wb_o                        = head_valid ? head.pc : 32'd0;
  assign occupancy_o                    = occ_q;
  assign instr_done_wb_o                = head_retire;
  assign perf_instr_ret_wb_o            = head_retire && head.count &&
                                          !(lsu_resp_valid_i && lsu_resp_err_i);
  assign perf_instr_ret_compressed_wb_o = perf_instr_ret_wb_o && head.compressed;

  assign lsu_wr    = rf_we_lsu_i && head_valid && (head.instr_type == WB_INSTR_LOAD);
  assign other_wr  = head_retire && head_is_other && head.we;
  assign port_busy = lsu_wr || other_wr;

  ibex_wb_aux_arb #(
    .NumAuxSrc     (NumAuxSrc),
    .AuxStarveLimit(AuxStarveLimit)
  ) u_aux_arb (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .req_i      (aux_req_i),
    .port_busy_i(port_busy),
    .gnt_o      (aux_gnt_o),
    .yield_o    (yield)
  );

  // x0 targets still consume the slot (and the aux grant) but never assert the write enable.
  always_comb begin
    rf_waddr_wb_o = '0;
    rf_wdata_wb_o = '0;
    rf_we_wb_o    = 1'b0;
    if (lsu_wr) begin
      rf_waddr_wb_o = head.waddr;
      rf_wdata_wb_o = rf_wdata_lsu_i;
      rf_we_wb_o    = 1'b1;
    end else if (other_wr) begin
      rf_waddr_wb_o = head.waddr;
      rf_wdata_wb_o = head.wdata;
      rf_we_wb_o    = 1'b1;
    end else begin
      for (int i = 0; i < NumAuxSrc; i++) begin
        if (aux_gnt_o[i]) begin
          rf_waddr_wb_o = aux_waddr_i[i*5 +: 5];
          rf_wdata_wb_o = aux_wdata_i[i*32 +: 32];
          rf_we_wb_o    = 1'b1;
        end
      end
    end
    if (rf_waddr_wb_o == 5'd0) rf_we_wb_o = 1'b0;
  end

  a_no_retire_empty : assert property (@(posedge clk_i) disable iff (!rst_ni)
    head_retire |-> head_valid);
  a_lsu_resp_head : assert property (@(posedge clk_i) disable iff (!rst_ni)
    lsu_resp_valid_i |-> (head_valid && !head_is_other));

endmodule

// File: tb/tb_ibex_wb_stage_mq.sv
// Bench for ibex_wb_stage_mq: directed scenarios plus random traffic against a queue-based model.
module tb_ibex_wb_stage_mq;
  import ibex_pkg::*;

  localparam int Depth = 2;
  localparam int NAux  = 2;
  localparam int Limit = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic                en_wb, compressed, perf_count, rf_we_id, rf_we_lsu, lsu_valid, lsu_err;
  wb_instr_type_e      instr_type;
  logic [31:0]         pc_id, rf_wdata_id, rf_wdata_lsu;
  logic [4:0]          rf_waddr_id, raddr_a, raddr_b;
  logic [NAux-1:0]     aux_req, aux_gnt;
  logic [NAux*5-1:0]   aux_waddr;
  logic [NAux*32-1:0]  aux_wdata;
  logic                ready_wb, haz_a, haz_b, out_ld, out_st, done, perf, perf_c, rf_we;
  logic [31:0]         pc_wb, rf_wdata;
  logic [2:0]          occ;
  logic [4:0]          rf_waddr;

  ibex_wb_stage_mq #(.WbDepth(Depth), .NumAuxSrc(NAux), .AuxStarveLimit(Limit)) dut (
    .clk_i(clk), .rst_ni(rst_n), .en_wb_i(en_wb), .instr_type_wb_i(instr_type),
    .pc_id_i(pc_id), .instr_is_compressed_id_i(compressed), .instr_perf_count_id_i(perf_count),
    .rf_waddr_id_i(rf_waddr_id), .rf_wdata_id_i(rf_wdata_id), .rf_we_id_i(rf_we_id),
    .rf_raddr_a_i(raddr_a), .rf_raddr_b_i(raddr_b), .rf_wdata_lsu_i(rf_wdata_lsu),
    .rf_we_lsu_i(rf_we_lsu), .lsu_resp_valid_i(lsu_valid), .lsu_resp_err_i(lsu_err),
    .aux_req_i(aux_req), .aux_waddr_i(aux_waddr), .aux_wdata_i(aux_wdata), .aux_gnt_o(aux_gnt),
    .ready_wb_o(ready_wb), .rf_hazard_a_o(haz_a), .rf_hazard_b_o(haz_b),
    .outstanding_load_wb_o(out_ld), .outstanding_store_wb_o(out_st), .pc_wb_o(pc_wb),
    .instr_done_wb_o(done), .perf_instr_ret_wb_o(perf),
    .perf_instr_ret_compressed_wb_o(perf_c), .occupancy_o(occ),
    .rf_waddr_wb_o(rf_waddr), .rf_wdata_wb_o(rf_wdata), .rf_we_wb_o(rf_we)
  );

  // ---------------- scoreboard / model state ----------------
  int              n_vec = 0;
  int              n_err = 0;
  wb_entry_t       mdl_q[$];
  int              starve = 0;
  logic [36:0]     exp_q[$];
  logic [NAux-1:0] last_gnt = '0;

  logic [NAux-1:0] exp_gnt;
  logic            exp_ready, exp_haz_a, exp_haz_b, exp_ld, exp_st, exp_done, exp_perf, exp_perf_c;
  logic            exp_we;
  logic [31:0]     exp_pc, exp_wdata;
  logic [4:0]      exp_waddr;
  logic [2:0]      exp_occ;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Expected outputs derived from the writeback rules applied to the model queue.
  task automatic model_eval();
    wb_entry_t h;
    bit        hv, is_oth, lsu_w, oth_w, yld, sel;
    hv     = mdl_q.size() > 0;
    h      = hv ? mdl_q[0] : '0;
    yld    = (starve == Limit);
    is_oth = hv && (h.instr_type == WB_INSTR_OTHER);
    exp_done = hv && (is_oth ? !(h.we && yld) : lsu_valid);
    lsu_w  = rf_we_lsu && hv && (h.instr_type == WB_INSTR_LOAD);
    oth_w  = exp_done && is_oth && h.we;
    exp_gnt = '0;
    if (!lsu_w && !oth_w) begin
      for (int i = 0; i < NAux; i++) begin
        if (aux_req[i] && exp_gnt == '0) exp_gnt[i] = 1'b1;
      end
    end
    sel = 1'b1;
    exp_waddr = '0;
    exp_wdata = '0;
    if (lsu_w) begin
      exp_waddr = h.waddr; exp_wdata = rf_wdata_lsu;
    end else if (oth_w) begin
      exp_waddr = h.waddr; exp_wdata = h.wdata;
    end else if (exp_gnt != '0) begin
      for (int i = 0; i < NAux; i++) begin
        if (exp_gnt[i]) begin
          exp_waddr = aux_waddr[i*5 +: 5]; exp_wdata = aux_wdata[i*32 +: 32];
        end
      end
    end else begin
      sel = 1'b0;
    end
    exp_we     = sel && (exp_waddr != 5'd0);
    exp_ready  = (mdl_q.size() < Depth) || exp_done;
    exp_haz_a  = 1'b0;
    exp_haz_b  = 1'b0;
    exp_ld     = 1'b0;
    exp_st     = 1'b0;
    foreach (mdl_q[k]) begin
      if ((mdl_q[k].we || mdl_q[k].instr_type == WB_INSTR_LOAD) && raddr_a != 0 &&
          mdl_q[k].waddr == raddr_a) exp_haz_a = 1'b1;
      if ((mdl_q[k].we || mdl_q[k].instr_type == WB_INSTR_LOAD) && raddr_b != 0 &&
          mdl_q[k].waddr == raddr_b) exp_haz_b = 1'b1;
      if (mdl_q[k].instr_type == WB_INSTR_LOAD) exp_ld = 1'b1;
      if (mdl_q[k].instr_type == WB_INSTR_STORE) exp_st = 1'b1;
    end
    exp_pc     = hv ? h.pc : 32'd0;
    exp_occ    = 3'(mdl_q.size());
    exp_perf   = exp_done && h.count && !(lsu_valid && lsu_err);
    exp_perf_c = exp_perf && h.compressed;
  endtask

  task automatic check_outputs();
    chk("aux_gnt", aux_gnt, exp_gnt);
    chk("ready", ready_wb, exp_ready);
    chk("haz_a", haz_a, exp_haz_a);
    chk("haz_b", haz_b, exp_haz_b);
    chk("out_load", out_ld, exp_ld);
    chk("out_store", out_st, exp_st);
    chk("pc_wb", pc_wb, exp_pc);
    chk("done", done, exp_done);
    chk("perf", perf, exp_perf);
    chk("perf_c", perf_c, exp_perf_c);
    chk("occupancy", occ, exp_occ);
    chk("rf_we", rf_we, exp_we);
    chk("rf_waddr", rf_waddr, exp_waddr);
    chk("rf_wdata", rf_wdata, exp_wdata);
    if (exp_we) exp_q.push_back({exp_waddr, exp_wdata});
    if (rf_we) begin
      if (exp_q.size() == 0) chk("rf_spurious", rf_we, 1'b0);
      else chk("rf_write", {rf_waddr, rf_wdata}, exp_q.pop_front());
    end
  endtask

  task automatic model_update();
    wb_entry_t e;
    if (exp_done) void'(mdl_q.pop_front());
    if (en_wb && exp_ready) begin
      e.instr_type = instr_type; e.pc = pc_id; e.compressed = compressed; e.count = perf_count;
      e.we = rf_we_id; e.waddr = rf_waddr_id; e.wdata = rf_wdata_id;
      mdl_q.push_back(e);
    end
    if (exp_gnt != '0) starve = 0;
    else if (aux_req != '0 && starve < Limit) starve++;
    last_gnt = exp_gnt;
  endtask

  task automatic model_reset();
    mdl_q.delete();
    exp_q.delete();
    starve   = 0;
    last_gnt = '0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic settle();
    #1;
    model_eval();
    check_outputs();
  endtask

  // Granted aux sources drop their request only after the clock edge that consumed it.
  task automatic advance();
    model_update();
    @(posedge clk);
    #1;
    aux_req = aux_req & ~last_gnt;
  endtask

  task automatic set_idle();
    en_wb = 0; instr_type = WB_INSTR_OTHER; pc_id = 0; compressed = 0; perf_count = 0;
    rf_we_id = 0; rf_waddr_id = 0; rf_wdata_id = 0; raddr_a = 0; raddr_b = 0;
    rf_wdata_lsu = 0; rf_we_lsu = 0; lsu_valid = 0; lsu_err = 0;
  endtask

  task automatic set_instr(input wb_instr_type_e t, input logic [31:0] pc, input logic [4:0] wa,
                           input logic [31:0] wd, input logic we);
    set_idle();
    en_wb = 1; instr_type = t; pc_id = pc; perf_count = 1;
    rf_waddr_id = wa; rf_wdata_id = wd; rf_we_id = we;
  endtask

  task automatic drive_random();
    bit lsu_head, load_head;
    en_wb        = ($urandom_range(0, 3) != 0);
    instr_type   = wb_instr_type_e'(2'($urandom_range(0, 2)));
    pc_id        = $urandom() & 32'hFFFF_FFFE;
    compressed   = 1'($urandom_range(0, 1));
    perf_count   = 1'($urandom_range(0, 1));
    rf_we_id     = 1'($urandom_range(0, 1));
    rf_waddr_id  = 5'($urandom_range(0, 7));
    rf_wdata_id  = $urandom();
    raddr_a      = 5'($urandom_range(0, 7));
    raddr_b      = 5'($urandom_range(0, 7));
    rf_wdata_lsu = $urandom();
    lsu_head  = mdl_q.size() > 0 && mdl_q[0].instr_type != WB_INSTR_OTHER;
    load_head = mdl_q.size() > 0 && mdl_q[0].instr_type == WB_INSTR_LOAD;
    lsu_valid = lsu_head && ($urandom_range(0, 1) == 1);
    lsu_err   = lsu_valid && ($urandom_range(0, 3) == 0);
    rf_we_lsu = lsu_valid && !lsu_err && load_head;
    for (int i = 0; i < NAux; i++) begin
      if (!aux_req[i] && $urandom_range(0, 3) == 0) begin
        aux_req[i]            = 1'b1;
        aux_waddr[i*5 +: 5]   = 5'($urandom_range(0, 31));
        aux_wdata[i*32 +: 32] = $urandom();
      end
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int  blocked;
    bit  got;
    rst_n = 0;
    set_idle();
    aux_req = '0; aux_waddr = '0; aux_wdata = '0;
    #2;
    chk("rst_ready", ready_wb, 1'b1);
    chk("rst_pc", pc_wb, 32'd0);
    chk("rst_occ", occ, 3'd0);
    chk("rst_we", rf_we, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1;

    // single OTHER writing x5
    set_instr(WB_INSTR_OTHER, 32'h100, 5'd5, 32'hDEAD, 1'b1);
    settle(); advance();
    set_idle();
    settle();
    chk("a_we", rf_we, 1'b1);
    chk("a_waddr", rf_waddr, 5'd5);
    chk("a_wdata", rf_wdata, 32'hDEAD);
    chk("a_done", done, 1'b1);
    advance();
    settle();
    chk("a_occ", occ, 3'd0);
    advance();

    // two outstanding loads fill the queue
    set_instr(WB_INSTR_LOAD, 32'h200, 5'd3, 32'h0, 1'b0);
    settle(); advance();
    set_instr(WB_INSTR_LOAD, 32'h204, 5'd4, 32'h0, 1'b0);
    settle(); advance();
    set_idle(); raddr_a = 5'd4;
    settle();
    chk("b_ready_full", ready_wb, 1'b0);
    chk("b_hazard", haz_a, 1'b1);
    advance();
    set_idle(); lsu_valid = 1; rf_we_lsu = 1; rf_wdata_lsu = 32'h11;
    settle();
    chk("b_we", rf_we, 1'b1);
    chk("b_waddr", rf_waddr, 5'd3);
    chk("b_wdata", rf_wdata, 32'h11);
    chk("b_ready", ready_wb, 1'b1);
    advance();
    set_idle(); lsu_valid = 1; rf_we_lsu = 1; rf_wdata_lsu = 32'h22;
    settle(); advance();

    // load error frees the port for a pending aux write
    set_instr(WB_INSTR_LOAD, 32'h300, 5'd7, 32'h0, 1'b0);
    settle(); advance();
    set_idle(); lsu_valid = 1; lsu_err = 1;
    aux_req[0] = 1'b1; aux_waddr[4:0] = 5'd9; aux_wdata[31:0] = 32'hA5A5;
    settle();
    chk("c_done", done, 1'b1);
    chk("c_perf", perf, 1'b0);
    chk("c_gnt", aux_gnt, 2'b01);
    chk("c_waddr", rf_waddr, 5'd9);
    chk("c_we", rf_we, 1'b1);
    advance();

    // two aux requests on an idle port: lowest index first
    set_idle();
    aux_req = 2'b11; aux_waddr = {5'd11, 5'd10}; aux_wdata = {32'h1111, 32'h1010};
    settle();
    chk("d_gnt_first", aux_gnt, 2'b01);
    advance();
    settle();
    chk("d_gnt_second", aux_gnt, 2'b10);
    advance();

    // OTHER/we stream starves aux[1] until the counter forces a yield
    set_instr(WB_INSTR_OTHER, 32'h400, 5'd6, 32'h600, 1'b1);
    settle(); advance();
    for (int r = 0; r < 2; r++) begin
      blocked = 0;
      got     = 0;
      aux_req[1] = 1'b1; aux_waddr[9:5] = 5'd12; aux_wdata[63:32] = 32'hC0DE_0000 + r;
      for (int c = 0; c < 20 && !got; c++) begin
        set_instr(WB_INSTR_OTHER, 32'h500 + 4 * c, 5'd6, $urandom(), 1'b1);
        settle();
        if (aux_gnt[1]) begin
          got = 1;
          chk("e_head_stall", done, 1'b0);
        end else begin
          blocked++;
        end
        advance();
      end
      chk("e_granted", got, 1'b1);
      chk("e_blocked_cycles", blocked, Limit);
    end
    set_idle();
    repeat (3) begin settle(); advance(); end

    // asynchronous reset with a full queue
    set_instr(WB_INSTR_LOAD, 32'h600, 5'd1, 32'h0, 1'b0);
    settle(); advance();
    set_instr(WB_INSTR_LOAD, 32'h604, 5'd2, 32'h0, 1'b0);
    settle(); advance();
    set_idle(); raddr_a = 5'd1;
    settle();
    chk("f_full", ready_wb, 1'b0);
    #2;
    rst_n = 0;
    #1;
    chk("f_ready", ready_wb, 1'b1);
    chk("f_occ", occ, 3'd0);
    chk("f_pc", pc_wb, 32'd0);
    chk("f_haz", haz_a, 1'b0);
    chk("f_load", out_ld, 1'b0);
    chk("f_we", rf_we, 1'b0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1;
    repeat (3) begin
      settle();
      chk("f_no_write", rf_we, 1'b0);
      advance();
    end

    // random traffic
    for (int n = 0; n < 1500; n++) begin
      drive_random();
      settle();
      advance();
    end

    // drain: answer every memory head, no new aux requests
    for (int n = 0; n < 40; n++) begin
      set_idle();
      if (mdl_q.size() > 0 && mdl_q[0].instr_type != WB_INSTR_OTHER) begin
        lsu_valid = 1;
        rf_we_lsu = (mdl_q[0].instr_type == WB_INSTR_LOAD);
        rf_wdata_lsu = $urandom();
      end
      settle();
      advance();
    end
    set_idle();
    settle();
    chk("end_occ", occ, 3'd0);
    chk("end_aux_idle", aux_req, '0);
    chk("end_scoreboard", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
